ps_ddr_rd_ctrl: RTL and testbench
=================================

PS_DDR_RD_CTRL -- requirements
Module: ps_ddr_rd_ctrl

Interface
REQ-001 The block SHALL use one clock, clk_ps, and an asynchronous, active-low reset, rst_n.
REQ-002 The block SHALL have parameter BURST_MAX, default 16, giving the maximum beats per AXI read burst (legal values 1..256).
REQ-003 Port clk_ps, input, 1 bit: rising-edge clock for all state.
REQ-004 Port rst_n, input, 1 bit: asynchronous reset, active low.
REQ-005 Port rd_start, input, 1 bit: single-cycle request to start a transfer.
REQ-006 Port rd_addr, input, 32 bits: byte start address; bits [1:0] are ignored (treated as 0).
REQ-007 Port rd_length, input, 32 bits: byte count; bits [1:0] are ignored; word count is rd_length[31:2].
REQ-008 Port rd_en, output, 1 bit: data-valid strobe, one per 32-bit word.
REQ-009 Port rd_data, output, 32 bits: read word, valid while rd_en=1.
REQ-010 Port rd_finish, output, 1 bit: one-cycle pulse when a transfer completes.
REQ-011 Port busy, output, 1 bit: high in every state except IDLE.
REQ-012 Port resp_err_cnt, output, 16 bits: count of beats with rresp≠0, saturating.
REQ-013 Ports m_axi_araddr (output, 32 bits), m_axi_arlen (output, 8 bits), m_axi_arsize (output, 3 bits, constant 3'b010) and m_axi_arburst (output, 2 bits, constant 2'b01) SHALL form the AXI4 read-address channel.
REQ-014 Ports m_axi_arvalid (output, 1 bit) and m_axi_arready (input, 1 bit) SHALL form the read-address handshake.
REQ-015 Ports m_axi_rdata (input, 32 bits), m_axi_rresp (input, 2 bits), m_axi_rlast (input, 1 bit), m_axi_rvalid (input, 1 bit) and m_axi_rready (output, 1 bit) SHALL form the AXI4 read-data channel.

Function
REQ-016 The block SHALL implement FSM states IDLE, ADDR, DATA and DONE.
REQ-017 In IDLE, on rd_start=1, the block SHALL latch the address and word count, clear resp_err_cnt, and go to ADDR if the word count is nonzero, or to DONE if it is zero.
REQ-018 rd_start SHALL be ignored in every state except IDLE.
REQ-019 On entry to ADDR, the burst beat count SHALL be min(remaining words, BURST_MAX, words left to the next 4 KB boundary); m_axi_arlen SHALL equal beats-1.
REQ-020 m_axi_arvalid SHALL be high throughout ADDR, with m_axi_araddr and m_axi_arlen held stable until m_axi_arready=1.
REQ-021 When m_axi_arready=1, the block SHALL go to DATA on the next cycle.
REQ-022 m_axi_rready SHALL be 1 in DATA and 0 in all other states.
REQ-023 Each beat with rvalid&rready SHALL produce rd_en=1 and rd_data=m_axi_rdata registered one cycle later; rd_en SHALL never be high for two words in one cycle.
REQ-024 On a beat with rresp≠0, resp_err_cnt SHALL increment, saturating at 0xFFFF; the data SHALL still be forwarded.
REQ-025 At the end of a burst (beat count reached), address SHALL advance by beats×4 and remaining words SHALL decrease by beats.
REQ-026 At the end of a burst, the FSM SHALL go to ADDR if remaining words are nonzero, otherwise to DONE.
REQ-027 Burst end SHALL be decided by the internal beat counter; m_axi_rlast SHALL be ignored for control.
REQ-028 DONE SHALL last exactly one cycle with rd_finish=1; rd_finish SHALL fall in the same cycle as the last rd_en, which is one cycle after the final beat; the FSM SHALL return to IDLE.
REQ-029 For a zero-length start, rd_finish SHALL pulse 2 cycles after rd_start, with no AXI traffic.
REQ-030 Only one read address SHALL be outstanding at a time.
REQ-031 Address arithmetic SHALL wrap modulo 2^32.

Reset
REQ-032 While rst_n=0, the block SHALL force state IDLE and rd_en, rd_finish, busy, m_axi_arvalid and m_axi_rready to 0.
REQ-033 While rst_n=0, rd_data, m_axi_araddr, m_axi_arlen and resp_err_cnt SHALL be 0.
REQ-034 A reset asserted mid-transfer SHALL abort the transfer with no rd_finish; after release, the next rd_start SHALL behave normally.

Verification
REQ-035 Scenario: rd_addr=0x1000_0000, rd_length=64, slave with no stalls -> one AR with arlen=15; 16 rd_en pulses carrying the slave data in order; one rd_finish.
REQ-036 Scenario: rd_length=0x48 (18 words) -> two ARs: arlen=15 at 0x1000_0000, then arlen=1 at 0x1000_0040; 18 rd_en pulses; one rd_finish.
REQ-037 Scenario: rd_addr=0x0000_0FF8, rd_length=32 -> ARs of 2 beats at 0xFF8 and 6 beats at 0x1000; no burst crosses the 4 KB boundary.
REQ-038 Scenario: rd_length=0 -> rd_finish 2 cycles after rd_start; m_axi_arvalid stays 0.
REQ-039 Scenario: random rvalid/arready stalls, plus a second rd_start while busy -> the second start is ignored; word count and order are exact.
REQ-040 Scenario: rresp=2'b10 on 3 beats -> resp_err_cnt=3 and all data forwarded; rst_n pulsed mid-burst -> outputs return to reset values and no rd_finish.

Source files
------------

// File: rtl/ps_ddr_rd_ctrl.sv
// AXI4 read-burst controller. It turns a (byte address, byte length) request
// into a sequence of single-outstanding INCR bursts that never cross a 4 KB
// page, and forwards each returned 32-bit word as a registered rd_en/rd_data
// strobe.
module ps_ddr_rd_ctrl #(
  parameter int BURST_MAX = 16
) (
  input  logic        clk_ps,
  input  logic        rst_n,
  input  logic        rd_start,
  input  logic [31:0] rd_addr,
  input  logic [31:0] rd_length,
  output logic        rd_en,
  output logic [31:0] rd_data,
  output logic        rd_finish,
  output logic        busy,
  output logic [15:0] resp_err_cnt,
  output logic [31:0] m_axi_araddr,
  output logic [7:0]  m_axi_arlen,
  output logic [2:0]  m_axi_arsize,
  output logic [1:0]  m_axi_arburst,
  output logic        m_axi_arvalid,
  input  logic        m_axi_arready,
  input  logic [31:0] m_axi_rdata,
  input  logic [1:0]  m_axi_rresp,
  input  logic        m_axi_rlast,
  input  logic        m_axi_rvalid,
  output logic        m_axi_rready
);

  localparam logic [29:0] BMAX = 30'(BURST_MAX);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_ADDR = 2'd1,
    S_DATA = 2'd2,
    S_DONE = 2'd3
  } state_t;

  state_t      state_q, state_d;
  logic [31:0] addr_q, addr_d;          // next word address to request
  logic [29:0] words_q, words_d;        // words still to be requested
  logic [8:0]  beats_q, beats_d;        // beats in the burst in flight
  logic [8:0]  beat_cnt_q, beat_cnt_d;  // beats received in this burst
  logic [31:0] araddr_q, araddr_d;
  logic [7:0]  arlen_q, arlen_d;
  logic        rd_en_q, rd_en_d;
  logic [31:0] rd_data_q, rd_data_d;
  logic [15:0] err_cnt_q, err_cnt_d;

  logic        load_burst;
  logic [8:0]  burst_w_clamp;
  logic [10:0] burst_to_bnd;
  logic [8:0]  burst_beats;

  // Burst end is counted internally, and the low address/length bits are
  // defined as don't-care, so these inputs are deliberately left unread.
  logic unused_inputs;
  assign unused_inputs = &{1'b0, m_axi_rlast, rd_addr[1:0], rd_length[1:0]};

  // Next-state, datapath and burst sizing; burst size is taken from the
  // post-update address/count so it is valid on every entry into ADDR.
  always_comb begin
    state_d       = state_q;
    addr_d        = addr_q;
    words_d       = words_q;
    beats_d       = beats_q;
    beat_cnt_d    = beat_cnt_q;
    araddr_d      = araddr_q;
    arlen_d       = arlen_q;
    rd_en_d       = 1'b0;
    rd_data_d     = rd_data_q;
    err_cnt_d     = err_cnt_q;
    load_burst    = 1'b0;
    burst_w_clamp = 9'd0;
    burst_to_bnd  = 11'd0;
    burst_beats   = 9'd0;

    case (state_q)
      S_IDLE: begin
        if (rd_start) begin
          addr_d    = {rd_addr[31:2], 2'b00};
          words_d   = rd_length[31:2];
          err_cnt_d = 16'd0;
          if (rd_length[31:2] != 30'd0) begin
            state_d    = S_ADDR;
            load_burst = 1'b1;
          end else begin
            state_d = S_DONE;
          end
        end
      end
      S_ADDR: begin
        if (m_axi_arready) begin
          state_d    = S_DATA;
          beat_cnt_d = 9'd0;
        end
      end
      S_DATA: begin
        if (m_axi_rvalid) begin
          rd_en_d   = 1'b1;
          rd_data_d = m_axi_rdata;
          if ((m_axi_rresp != 2'b00) && (err_cnt_q != 16'hFFFF)) begin
            err_cnt_d = err_cnt_q + 16'd1;
          end
          if (beat_cnt_q == (beats_q - 9'd1)) begin
            addr_d  = addr_q + {21'd0, beats_q, 2'b00};
            words_d = words_q - {21'd0, beats_q};
            if (words_d != 30'd0) begin
              state_d    = S_ADDR;
              load_burst = 1'b1;
            end else begin
              state_d = S_DONE;
            end
          end else begin
            beat_cnt_d = beat_cnt_q + 9'd1;
          end
        end
      end
      S_DONE: begin
        state_d = S_IDLE;
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase

    // min(remaining words, BURST_MAX, words left in the current 4 KB page)
    burst_w_clamp = (words_d > BMAX) ? BMAX[8:0] : words_d[8:0];
    burst_to_bnd  = 11'd1024 - {1'b0, addr_d[11:2]};
    burst_beats   = ({2'b00, burst_w_clamp} < burst_to_bnd) ? burst_w_clamp
                                                             : burst_to_bnd[8:0];
    if (load_burst) begin
      beats_d  = burst_beats;
      araddr_d = addr_d;
      arlen_d  = 8'(burst_beats - 9'd1);
    end
  end

  // State and datapath registers, cleared asynchronously.
  always_ff @(posedge clk_ps or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= S_IDLE;
      addr_q     <= 32'd0;
      words_q    <= 30'd0;
      beats_q    <= 9'd0;
      beat_cnt_q <= 9'd0;
      araddr_q   <= 32'd0;
      arlen_q    <= 8'd0;
      rd_en_q    <= 1'b0;
      rd_data_q  <= 32'd0;
      err_cnt_q  <= 16'd0;
    end else begin
      state_q    <= state_d;
      addr_q     <= addr_d;
      words_q    <= words_d;
      beats_q    <= beats_d;
      beat_cnt_q <= beat_cnt_d;
      araddr_q   <= araddr_d;
      arlen_q    <= arlen_d;
      rd_en_q    <= rd_en_d;
      rd_data_q  <= rd_data_d;
      err_cnt_q  <= err_cnt_d;
    end
  end

  assign rd_en         = rd_en_q;
  assign rd_data       = rd_data_q;
  assign rd_finish     = (state_q == S_DONE);
  assign busy          = (state_q != S_IDLE);
  assign resp_err_cnt  = err_cnt_q;
  assign m_axi_araddr  = araddr_q;
  assign m_axi_arlen   = arlen_q;
  assign m_axi_arsize  = 3'b010;
  assign m_axi_arburst = 2'b01;
  assign m_axi_arvalid = (state_q == S_ADDR);
  assign m_axi_rready  = (state_q == S_DATA);

endmodule

// File: tb/tb_ps_ddr_rd_ctrl.sv
// Scoreboard bench for ps_ddr_rd_ctrl: directed transfers push expected AR
// beats, data words and finish pulses into queues; an AXI slave model answers
// the read requests and a monitor pops and compares whatever the DUT emits.
`timescale 1ns/1ps
module tb_ps_ddr_rd_ctrl;

  logic        clk_ps = 1'b0;
  logic        rst_n  = 1'b0;
  logic        rd_start;
  logic [31:0] rd_addr;
  logic [31:0] rd_length;
  logic        rd_en;
  logic [31:0] rd_data;
  logic        rd_finish;
  logic        busy;
  logic [15:0] resp_err_cnt;
  logic [31:0] m_axi_araddr;
  logic [7:0]  m_axi_arlen;
  logic [2:0]  m_axi_arsize;
  logic [1:0]  m_axi_arburst;
  logic        m_axi_arvalid;
  logic        m_axi_arready;
  logic [31:0] m_axi_rdata;
  logic [1:0]  m_axi_rresp;
  logic        m_axi_rlast;
  logic        m_axi_rvalid;
  logic        m_axi_rready;

  ps_ddr_rd_ctrl #(.BURST_MAX(16)) dut (
    .clk_ps        (clk_ps),
    .rst_n         (rst_n),
    .rd_start      (rd_start),
    .rd_addr       (rd_addr),
    .rd_length     (rd_length),
    .rd_en         (rd_en),
    .rd_data       (rd_data),
    .rd_finish     (rd_finish),
    .busy          (busy),
    .resp_err_cnt  (resp_err_cnt),
    .m_axi_araddr  (m_axi_araddr),
    .m_axi_arlen   (m_axi_arlen),
    .m_axi_arsize  (m_axi_arsize),
    .m_axi_arburst (m_axi_arburst),
    .m_axi_arvalid (m_axi_arvalid),
    .m_axi_arready (m_axi_arready),
    .m_axi_rdata   (m_axi_rdata),
    .m_axi_rresp   (m_axi_rresp),
    .m_axi_rlast   (m_axi_rlast),
    .m_axi_rvalid  (m_axi_rvalid),
    .m_axi_rready  (m_axi_rready)
  );

  always #5 clk_ps = ~clk_ps;

  int n_cmp = 0;
  int n_err = 0;

  logic [31:0] exp_data[$];
  logic [39:0] exp_ar[$];   // {araddr, arlen}
  logic        exp_fin[$];  // 1: last rd_en must coincide with rd_finish

  // slave controls written only by the stimulus process
  bit          stall_en = 1'b0;
  logic [63:0] err_mask = 64'd0;
  logic [31:0] err_base = 32'd0;

  function automatic logic [31:0] mem_word(input logic [31:0] a);
    return a ^ 32'hC0DE_5A5A;
  endfunction

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] req);
    n_cmp++;
    if (act !== req) begin
      n_err++;
      $display("FAIL %s: got 0x%0h, required 0x%0h", name, act, req);
    end
  endtask

  task automatic push_ar(input logic [31:0] a, input logic [7:0] len);
    exp_ar.push_back({a, len});
  endtask

  task automatic expect_xfer(input logic [31:0] a, input int n);
    for (int i = 0; i < n; i++) exp_data.push_back(mem_word(a + 32'(4 * i)));
    exp_fin.push_back(n != 0);
  endtask

  task automatic start(input logic [31:0] a, input logic [31:0] len);
    @(posedge clk_ps); #1;
    rd_start  = 1'b1;
    rd_addr   = a;
    rd_length = len;
    @(posedge clk_ps); #1;
    rd_start  = 1'b0;
  endtask

  task automatic wait_done(input string tag, input int budget);
    for (int i = 0; i < budget; i++) begin
      @(negedge clk_ps);
      if (exp_fin.size() == 0 && exp_data.size() == 0 && !busy) break;
    end
    check({tag, "_words_left"}, 64'(exp_data.size()), 64'd0);
    check({tag, "_ar_left"}, 64'(exp_ar.size()), 64'd0);
    check({tag, "_finish_left"}, 64'(exp_fin.size()), 64'd0);
    check({tag, "_busy_after"}, 64'(busy), 64'd0);
    $display("xfer %s: done, %0d compared so far", tag, n_cmp);
  endtask

  task automatic check_reset_vals(input string tag);
    check({tag, "_rd_en"}, 64'(rd_en), 64'd0);
    check({tag, "_rd_finish"}, 64'(rd_finish), 64'd0);
    check({tag, "_busy"}, 64'(busy), 64'd0);
    check({tag, "_arvalid"}, 64'(m_axi_arvalid), 64'd0);
    check({tag, "_rready"}, 64'(m_axi_rready), 64'd0);
    check({tag, "_rd_data"}, 64'(rd_data), 64'd0);
    check({tag, "_araddr"}, 64'(m_axi_araddr), 64'd0);
    check({tag, "_arlen"}, 64'(m_axi_arlen), 64'd0);
    check({tag, "_err_cnt"}, 64'(resp_err_cnt), 64'd0);
  endtask

  // AXI read slave: accepts one burst, returns mem_word() beats, optional
  // random stalls and rresp errors on selected word indices.
  initial begin : slave
    bit          ar_hs, r_hs, cur_act;
    logic [31:0] hs_addr, cur_addr, idx;
    logic [7:0]  hs_len;
    int          cur_left;
    cur_act = 1'b0; cur_addr = 32'd0; cur_left = 0;
    m_axi_arready = 1'b0; m_axi_rvalid = 1'b0; m_axi_rdata = 32'd0;
    m_axi_rresp = 2'b00; m_axi_rlast = 1'b0;
    forever begin
      @(negedge clk_ps);
      ar_hs   = m_axi_arvalid && m_axi_arready;
      r_hs    = m_axi_rvalid && m_axi_rready;
      hs_addr = m_axi_araddr;
      hs_len  = m_axi_arlen;
      @(posedge clk_ps); #1;
      if (!rst_n) begin
        cur_act  = 1'b0;
        cur_left = 0;
      end else begin
        if (r_hs && cur_act) begin
          cur_addr = cur_addr + 32'd4;
          cur_left--;
          if (cur_left == 0) cur_act = 1'b0;
        end
        if (ar_hs) begin
          check("ar_outstanding", 64'(cur_act), 64'd0);
          cur_act  = 1'b1;
          cur_addr = hs_addr;
          cur_left = int'(hs_len) + 1;
        end
      end
      m_axi_arready = rst_n && (!stall_en || ($urandom_range(0, 2) != 0));
      if (!cur_act || !rst_n) begin
        m_axi_rvalid = 1'b0;
      end else if (!(m_axi_rvalid && !r_hs)) begin
        m_axi_rvalid = !stall_en || ($urandom_range(0, 3) != 0);
      end
      idx         = (cur_addr - err_base) >> 2;
      m_axi_rdata = mem_word(cur_addr);
      m_axi_rresp = (idx < 32'd64 && err_mask[idx[5:0]]) ? 2'b10 : 2'b00;
      m_axi_rlast = (cur_left == 1);
    end
  end

  // Monitor: compares every DUT output event against the scoreboard queues.
  initial begin : monitor
    logic [39:0] e;
    logic [39:0] ar_hold;
    bit          ar_wait;
    bit          f;
    ar_wait = 1'b0;
    ar_hold = 40'd0;
    forever begin
      @(negedge clk_ps);
      if (!rst_n) begin
        ar_wait = 1'b0;
      end else begin
        if (rd_en) begin
          if (exp_data.size() == 0) begin
            n_cmp++; n_err++;
            $display("FAIL rd_en_extra: got word 0x%0h, required no rd_en", rd_data);
          end else begin
            check("rd_data", 64'(rd_data), 64'(exp_data.pop_front()));
          end
        end
        if (ar_wait) begin
          check("ar_hold_valid", 64'(m_axi_arvalid), 64'd1);
          check("ar_hold_addr_len", 64'({m_axi_araddr, m_axi_arlen}), 64'(ar_hold));
        end
        ar_wait = m_axi_arvalid && !m_axi_arready;
        ar_hold = {m_axi_araddr, m_axi_arlen};
        if (m_axi_arvalid && m_axi_arready) begin
          if (exp_ar.size() == 0) begin
            n_cmp++; n_err++;
            $display("FAIL ar_extra: got araddr 0x%0h arlen %0d, required no AR", m_axi_araddr, m_axi_arlen);
          end else begin
            e = exp_ar.pop_front();
            check("araddr", 64'(m_axi_araddr), 64'(e[39:8]));
            check("arlen", 64'(m_axi_arlen), 64'(e[7:0]));
          end
          check("arsize", 64'(m_axi_arsize), 64'd2);
          check("arburst", 64'(m_axi_arburst), 64'd1);
        end
        if (rd_finish) begin
          if (exp_fin.size() == 0) begin
            n_cmp++; n_err++;
            $display("FAIL finish_extra: got rd_finish 1, required 0");
          end else begin
            f = exp_fin.pop_front();
            check("finish_with_last_rd_en", 64'(rd_en), 64'(f));
            if (f) check("finish_words_left", 64'(exp_data.size()), 64'd0);
          end
        end
      end
    end
  end

  initial begin : stimulus
    rd_start = 1'b0; rd_addr = 32'd0; rd_length = 32'd0;

    // reset state
    repeat (3) @(posedge clk_ps);
    #2 check_reset_vals("por");
    @(posedge clk_ps); #1 rst_n = 1'b1;

    // 64 bytes, no stalls: one 16-beat burst
    push_ar(32'h1000_0000, 8'd15);
    expect_xfer(32'h1000_0000, 16);
    start(32'h1000_0000, 32'd64);
    wait_done("single16", 300);

    // 18 words: 16 + 2
    push_ar(32'h1000_0000, 8'd15);
    push_ar(32'h1000_0040, 8'd1);
    expect_xfer(32'h1000_0000, 18);
    start(32'h1000_0000, 32'h48);
    wait_done("split18", 300);

    // 4 KB boundary: 2 beats then 6 beats; low address bits ignored
    push_ar(32'h0000_0FF8, 8'd1);
    push_ar(32'h0000_1000, 8'd5);
    expect_xfer(32'h0000_0FF8, 8);
    start(32'h0000_0FFB, 32'd35);
    wait_done("page4k", 300);

    // address wrap at 2^32
    push_ar(32'hFFFF_FFF0, 8'd3);
    push_ar(32'h0000_0000, 8'd3);
    expect_xfer(32'hFFFF_FFF0, 8);
    start(32'hFFFF_FFF0, 32'd32);
    wait_done("wrap", 300);

    // zero length: finish on the second edge after rd_start is driven
    exp_fin.push_back(1'b0);
    start(32'h1234_0000, 32'd3);
    @(negedge clk_ps);
    check("zero_finish_hi", 64'(rd_finish), 64'd1);
    check("zero_arvalid", 64'(m_axi_arvalid), 64'd0);
    @(negedge clk_ps);
    check("zero_finish_lo", 64'(rd_finish), 64'd0);
    wait_done("zero", 20);

    // random stalls, with a second rd_start while busy that must be ignored
    stall_en = 1'b1;
    push_ar(32'h2000_0100, 8'd15);
    push_ar(32'h2000_0140, 8'd15);
    push_ar(32'h2000_0180, 8'd15);
    push_ar(32'h2000_01C0, 8'd15);
    expect_xfer(32'h2000_0100, 64);
    start(32'h2000_0100, 32'h100);
    repeat (20) @(posedge clk_ps);
    #1 check("busy_mid_stall", 64'(busy), 64'd1);
    start(32'h5555_0000, 32'h40);
    wait_done("stall64", 3000);
    stall_en = 1'b0;

    // rresp errors on words 1, 4 and 7 of a 10-word read
    err_base = 32'h3000_0000;
    err_mask = 64'h0000_0000_0000_0092;
    push_ar(32'h3000_0000, 8'd9);
    expect_xfer(32'h3000_0000, 10);
    start(32'h3000_0000, 32'd40);
    wait_done("rresp", 300);
    check("resp_err_cnt_3", 64'(resp_err_cnt), 64'd3);
    err_mask = 64'd0;

    // reset mid-burst: transfer abandoned, no finish afterwards
    push_ar(32'h1000_0000, 8'd15);
    expect_xfer(32'h1000_0000, 16);
    start(32'h1000_0000, 32'd64);
    repeat (6) @(posedge clk_ps);
    #1 rst_n = 1'b0;
    exp_data.delete();
    exp_ar.delete();
    exp_fin.delete();
    #1 check_reset_vals("mid");
    repeat (3) @(posedge clk_ps);
    #1 rst_n = 1'b1;
    repeat (20) @(posedge clk_ps);
    #1 check("post_reset_busy", 64'(busy), 64'd0);

    // normal transfer after the abort
    push_ar(32'h4000_0000, 8'd1);
    expect_xfer(32'h4000_0000, 2);
    start(32'h4000_0000, 32'd8);
    wait_done("after_rst", 300);
    check("resp_err_cnt_0", 64'(resp_err_cnt), 64'd0);

    repeat (10) @(posedge clk_ps);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
